fetch_unit: RTL

- Instruction fetch stage. It produces the IF/ID stream (inst_ifid_p1, pc_p1, epc_p1) that the decode stage consumes.
- It consumes decode's control-flow outputs (halt, illegal op, return-from-exception, jump displacement) and the execute-stage redirect.
- It sits between the instruction memory port and decode, and buffers fetched words in a small in-order queue.

---
 rtl/fetch_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with an in-order instruction queue, credit-based
// request issue and redirect/drain handling. Optional: `FETCH_BYPASS_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] EXC_VEC  = 16'h0002,
  parameter int          IQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_ifmem_p1,
  output logic [15:0] imem_addr_ifmem_p1,
  input  logic        imem_gnt_memif_p1,
  input  logic        imem_rvalid_memif_p1,
  input  logic [15:0] imem_rdata_memif_p1,
  output logic [15:0] inst_ifid_p1,
  output logic        inst_valid_ifid_p1,
  output logic [15:0] pc_p1,
  output logic [15:0] epc_p1,
  input  logic        stall_idif_p1,
  input  logic        halt_idif_p1,
  input  logic        illegal_op_idif_p1,
  input  logic        return_execution_idif_p1,
  input  logic        jmp_displacement_idif_p1,
  input  logic [15:0] jmp_displacement_value_idif_p1,
  input  logic        redirect_exif_p1,
  input  logic [15:0] redirect_pc_exif_p1,
  output logic        halted_ifout_p1
);

  localparam int AW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(IQ_DEPTH);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [15:0]   fetch_pc;
  logic [15:0]   resp_pc;
  logic [15:0]   epc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [15:0]   q_inst [IQ_DEPTH];
  logic [15:0]   q_pc   [IQ_DEPTH];

  logic          live;
  logic          head_vld;
  logic          bypass;
  logic          consume;
  logic          ex_redir;
  logic          dec_ok;
  logic          sel_rti;
  logic          sel_ill;
  logic          sel_jmp;
  logic          halt_now;
  logic          redir_now;
  logic          flush;
  logic [15:0]   redir_tgt;
  logic          resp_ok;
  logic          accepted;
  logic          enq;
  logic          deq;
  logic          fire;
  logic [CW:0]   credit;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] drop_nxt;

  assign live     = state != ST_HALTED;
  assign head_vld = count != '0;

`ifdef FETCH_BYPASS_EN
  // An empty queue lets a fresh response reach decode in the same cycle.
  assign bypass = ~head_vld & imem_rvalid_memif_p1
                & (drop == '0) & (state == ST_RUN);
  assign inst_ifid_p1 = head_vld ? q_inst[head] : imem_rdata_memif_p1;
  assign pc_p1        = head_vld ? q_pc[head]   : resp_pc;
`else
  assign bypass       = 1'b0;
  assign inst_ifid_p1 = q_inst[head];
  assign pc_p1        = q_pc[head];
`endif

  assign inst_valid_ifid_p1 = head_vld | bypass;
  assign consume = inst_valid_ifid_p1 & ~stall_idif_p1;

  assign ex_redir = live & redirect_exif_p1;
  assign halt_now = live & consume & halt_idif_p1 & ~redirect_exif_p1;
  assign dec_ok   = live & consume & ~redirect_exif_p1 & ~halt_idif_p1;
  assign sel_rti  = dec_ok & return_execution_idif_p1;
  assign sel_ill  = dec_ok & ~return_execution_idif_p1
                  & illegal_op_idif_p1;
  assign sel_jmp  = dec_ok & ~return_execution_idif_p1
                  & ~illegal_op_idif_p1 & jmp_displacement_idif_p1;

  assign redir_now = ex_redir | sel_rti | sel_ill | sel_jmp;
  assign flush     = redir_now | halt_now;

  always_comb begin
    redir_tgt = fetch_pc;
    unique case (1'b1)
      ex_redir: redir_tgt = redirect_pc_exif_p1;
      sel_rti:  redir_tgt = epc;
      sel_ill:  redir_tgt = EXC_VEC;
      sel_jmp:  redir_tgt = pc_p1 + 16'd2
                          + jmp_displacement_value_idif_p1;
      default:  redir_tgt = fetch_pc;
    endcase
  end

  assign resp_ok  = imem_rvalid_memif_p1 & (drop == '0) & live;
  assign accepted = resp_ok & ~flush;
  assign enq      = accepted & ~(bypass & consume);
  assign deq      = consume & head_vld & ~flush;

  assign credit = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_ifmem_p1 = ~rst & (state == ST_RUN)
                           & (credit < {1'b0, DEPTH}) & ~flush;
  assign imem_addr_ifmem_p1 = fetch_pc;
  assign fire = imem_req_ifmem_p1 & imem_gnt_memif_p1;

  // Requests are blocked on flush, so only a response can retire here.
  assign in_flight = outstanding - CW'(imem_rvalid_memif_p1);
  assign out_nxt   = outstanding + CW'(fire)
                   - CW'(imem_rvalid_memif_p1);

  always_comb begin
    drop_nxt = drop;
    if (flush)
      drop_nxt = in_flight;
    else if (imem_rvalid_memif_p1 && drop != '0)
      drop_nxt = drop - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    if (halt_now)
      state_nxt = ST_HALTED;
    else if (redir_now)
      state_nxt = (drop_nxt != '0) ? ST_DRAIN : ST_RUN;
    else if (state == ST_DRAIN && drop_nxt == '0)
      state_nxt = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      epc         <= '0;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      drop        <= drop_nxt;
      if (sel_ill)
        epc <= pc_p1 + 16'd2;
      if (flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        count <= count + CW'(enq) - CW'(deq);
        if (enq)
          tail <= tail + AW'(1);
        if (deq)
          head <= head + AW'(1);
      end
      if (redir_now) begin
        fetch_pc <= redir_tgt;
        resp_pc  <= redir_tgt;
      end else begin
        if (fire)
          fetch_pc <= fetch_pc + 16'd2;
        if (accepted)
          resp_pc <= resp_pc + 16'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[tail] <= imem_rdata_memif_p1;
      q_pc[tail]   <= resp_pc;
    end
  end

  assign epc_p1          = epc;
  assign halted_ifout_p1 = state == ST_HALTED;

endmodule
